// File: rtl/interrupt_unit_p.sv
// Interrupt/exception unit beside commit: latches causes, masks and prioritises them, and saves/restores exception state.
// jisr and redirect are combinational in the commit cycle; SPR updates are visible next cycle; there is no backpressure.
module interrupt_unit_p #(
    parameter int                  XLEN        = 32,
    parameter int                  N_CAUSE     = 23,
    parameter int                  N_INTERNAL  = 7,
    parameter logic [N_CAUSE-1:0]  REPEAT_MASK = 'h3E,
    parameter logic [XLEN-1:0]     SISR        = '0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N_CAUSE-1:0] ca_i,
    input  logic               commit_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    next_pc_i,
    input  logic [XLEN-1:0]    ea_i,
    input  logic               eret_i,
    input  logic               spr_we_i,
    input  logic [2:0]         spr_a_i,
    input  logic [XLEN-1:0]    spr_wd_i,
    output logic [XLEN-1:0]    spr_rd_o,
    output logic [XLEN-1:0]    sr_o,
    output logic [XLEN-1:0]    esr_o,
    output logic [XLEN-1:0]    eca_o,
    output logic [XLEN-1:0]    epc_o,
    output logic [XLEN-1:0]    edata_o,
    output logic [XLEN-1:0]    pto_o,
    output logic [XLEN-1:0]    ptl_o,
    output logic               mode_o,
    output logic               jisr_o,
    output logic [4:0]         il_o,
    output logic               redirect_o,
    output logic [XLEN-1:0]    redirect_pc_o
);

    function automatic logic [N_CAUSE-1:0] int_mask_f();
        logic [N_CAUSE-1:0] m;
        m = '0;
        for (int i = 0; i < N_CAUSE; i++) begin
            m[i] = (i < N_INTERNAL);
        end
        return m;
    endfunction

    localparam logic [N_CAUSE-1:0] INT_MASK = int_mask_f();
    localparam logic [N_CAUSE-1:0] EXT_MASK = ~INT_MASK;

    localparam logic [2:0] SPR_SR    = 3'd0;
    localparam logic [2:0] SPR_ESR   = 3'd1;
    localparam logic [2:0] SPR_ECA   = 3'd2;
    localparam logic [2:0] SPR_EPC   = 3'd3;
    localparam logic [2:0] SPR_EDATA = 3'd4;
    localparam logic [2:0] SPR_PTO   = 3'd5;
    localparam logic [2:0] SPR_PTL   = 3'd6;
    localparam logic [2:0] SPR_MODE  = 3'd7;

    logic [XLEN-1:0]    sr_q, sr_d, esr_q, esr_d, eca_q, eca_d, epc_q, epc_d;
    logic [XLEN-1:0]    edata_q, edata_d, pto_q, pto_d, ptl_q, ptl_d;
    logic               mode_q, mode_d, emode_q, emode_d;
    logic [N_CAUSE-1:0] pend_q, pend_d;

    logic [N_CAUSE-1:0] eff;
    logic [N_CAUSE-1:0] sel_oh;
    logic [4:0]         il_sel;
    logic               take, do_eret, do_wr, is_repeat;

    // Internal causes bypass both the sticky latch and the SR mask.
    always_comb begin
        eff = (ca_i & INT_MASK) | ((pend_q | ca_i) & EXT_MASK & sr_q[N_CAUSE-1:0]);
    end

    always_comb begin
        il_sel = '0;
        sel_oh = '0;
        for (int i = N_CAUSE - 1; i >= 0; i--) begin
            if (eff[i]) begin
                il_sel = 5'(i);
                sel_oh = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign take      = rst_n_i & commit_i & (|eff);
    assign do_eret   = rst_n_i & commit_i & eret_i & ~take & ~mode_q;
    assign do_wr     = rst_n_i & commit_i & spr_we_i & ~take & ~do_eret & ~mode_q;
    assign is_repeat = |(sel_oh & REPEAT_MASK);

    always_comb begin
        sr_d    = sr_q;
        esr_d   = esr_q;
        eca_d   = eca_q;
        epc_d   = epc_q;
        edata_d = edata_q;
        pto_d   = pto_q;
        ptl_d   = ptl_q;
        mode_d  = mode_q;
        emode_d = emode_q;
        pend_d  = (pend_q | ca_i) & EXT_MASK;
        if (take) begin
            esr_d   = sr_q;
            sr_d    = '0;
            eca_d   = XLEN'(eff);
            edata_d = ea_i;
            epc_d   = is_repeat ? pc_i : next_pc_i;
            emode_d = mode_q;
            mode_d  = 1'b0;
            // A cause raised and taken in the same cycle must not stay pending.
            pend_d  = pend_d & ~sel_oh;
        end else if (do_eret) begin
            sr_d   = esr_q;
            mode_d = emode_q;
        end else if (do_wr) begin
            case (spr_a_i)
                SPR_SR:    sr_d    = spr_wd_i;
                SPR_ESR:   esr_d   = spr_wd_i;
                SPR_ECA:   eca_d   = spr_wd_i;
                SPR_EPC:   epc_d   = spr_wd_i;
                SPR_EDATA: edata_d = spr_wd_i;
                SPR_PTO:   pto_d   = spr_wd_i;
                SPR_PTL:   ptl_d   = spr_wd_i;
                default:   mode_d  = spr_wd_i[0];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sr_q    <= '0;
            esr_q   <= '0;
            eca_q   <= '0;
            epc_q   <= '0;
            edata_q <= '0;
            pto_q   <= '0;
            ptl_q   <= '0;
            mode_q  <= 1'b0;
            emode_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            sr_q    <= sr_d;
            esr_q   <= esr_d;
            eca_q   <= eca_d;
            epc_q   <= epc_d;
            edata_q <= edata_d;
            pto_q   <= pto_d;
            ptl_q   <= ptl_d;
            mode_q  <= mode_d;
            emode_q <= emode_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        spr_rd_o = '0;
        case (spr_a_i)
            SPR_SR:    spr_rd_o = sr_q;
            SPR_ESR:   spr_rd_o = esr_q;
            SPR_ECA:   spr_rd_o = eca_q;
            SPR_EPC:   spr_rd_o = epc_q;
            SPR_EDATA: spr_rd_o = edata_q;
            SPR_PTO:   spr_rd_o = pto_q;
            SPR_PTL:   spr_rd_o = ptl_q;
            SPR_MODE:  spr_rd_o = XLEN'(mode_q);
            default:   spr_rd_o = '0;
        endcase
    end

    assign sr_o          = sr_q;
    assign esr_o         = esr_q;
    assign eca_o         = eca_q;
    assign epc_o         = epc_q;
    assign edata_o       = edata_q;
    assign pto_o         = pto_q;
    assign ptl_o         = ptl_q;
    assign mode_o        = mode_q;
    assign jisr_o        = take;
    assign il_o          = il_sel;
    assign redirect_o    = take | (rst_n_i & commit_i & eret_i);
    assign redirect_pc_o = take ? SISR : epc_q;

endmodule

// File: tb/tb_interrupt_unit_p.sv
// Bench for interrupt_unit_p: cause-level reference model checked every cycle, plus directed literal checks.
module tb_interrupt_unit_p;
    localparam int          XLEN   = 32;
    localparam int          NC     = 23;
    localparam int          NI     = 7;
    localparam logic [NC-1:0] RM   = 23'h3E;
    localparam logic [31:0] SISR_T = 32'h0000_0080;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] ca;
    logic          commit, eret, spr_we;
    logic [31:0]   pc, next_pc, ea, spr_wd;
    logic [2:0]    spr_a;
    logic [31:0]   spr_rd, sr, esr, eca, epc, edata, pto, ptl, redirect_pc;
    logic          mode, jisr, redirect;
    logic [4:0]    il;

    always #5 clk = ~clk;

    interrupt_unit_p #(
        .XLEN(XLEN), .N_CAUSE(NC), .N_INTERNAL(NI), .REPEAT_MASK(RM), .SISR(SISR_T)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ca_i(ca), .commit_i(commit), .pc_i(pc),
        .next_pc_i(next_pc), .ea_i(ea), .eret_i(eret), .spr_we_i(spr_we),
        .spr_a_i(spr_a), .spr_wd_i(spr_wd), .spr_rd_o(spr_rd), .sr_o(sr),
        .esr_o(esr), .eca_o(eca), .epc_o(epc), .edata_o(edata), .pto_o(pto),
        .ptl_o(ptl), .mode_o(mode), .jisr_o(jisr), .il_o(il),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain variables.
    logic [31:0] m_sr, m_esr, m_eca, m_epc, m_edata, m_pto, m_ptl;
    logic        m_mode, m_emode;
    bit          m_pend [NC];

    function automatic logic [NC-1:0] m_active();
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) begin
            if (i < NI) r[i] = ca[i];
            else        r[i] = (m_pend[i] || ca[i]) && m_sr[i];
        end
        return r;
    endfunction

    function automatic int m_pick(input logic [NC-1:0] a);
        for (int i = 0; i < NC; i++) if (a[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_spr(input logic [2:0] a);
        case (a)
            3'd0: return m_sr;
            3'd1: return m_esr;
            3'd2: return m_eca;
            3'd3: return m_epc;
            3'd4: return m_edata;
            3'd5: return m_pto;
            3'd6: return m_ptl;
            default: return {31'b0, m_mode};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [NC-1:0] a;
        int s;
        if (!rst_n) begin
            m_sr = 0; m_esr = 0; m_eca = 0; m_epc = 0; m_edata = 0; m_pto = 0; m_ptl = 0;
            m_mode = 0; m_emode = 0;
            for (int i = 0; i < NC; i++) m_pend[i] = 0;
            started = 1;
        end else if (started) begin
            a = m_active();
            s = m_pick(a);
            for (int i = NI; i < NC; i++) if (ca[i]) m_pend[i] = 1;
            if (commit && s >= 0) begin
                m_esr = m_sr; m_sr = 0; m_eca = 32'(a); m_edata = ea;
                m_epc = RM[s] ? pc : next_pc;
                m_emode = m_mode; m_mode = 0;
                if (s >= NI) m_pend[s] = 0;
            end else if (commit && eret && !m_mode) begin
                m_sr = m_esr; m_mode = m_emode;
            end else if (commit && spr_we && !m_mode) begin
                case (spr_a)
                    3'd0: m_sr = spr_wd;
                    3'd1: m_esr = spr_wd;
                    3'd2: m_eca = spr_wd;
                    3'd3: m_epc = spr_wd;
                    3'd4: m_edata = spr_wd;
                    3'd5: m_pto = spr_wd;
                    3'd6: m_ptl = spr_wd;
                    default: m_mode = spr_wd[0];
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [NC-1:0] a;
        int s;
        bit j;
        if (started) begin
            a = m_active();
            s = m_pick(a);
            j = rst_n && commit && (s >= 0);
            chk("jisr", {31'b0, jisr}, {31'b0, j});
            if (j) chk("il", {27'b0, il}, s);
            chk("redirect", {31'b0, redirect}, {31'b0, j || (rst_n && commit && eret)});
            chk("redirect_pc", redirect_pc, j ? SISR_T : m_epc);
            chk("sr", sr, m_sr);
            chk("esr", esr, m_esr);
            chk("eca", eca, m_eca);
            chk("epc", epc, m_epc);
            chk("edata", edata, m_edata);
            chk("pto", pto, m_pto);
            chk("ptl", ptl, m_ptl);
            chk("mode", {31'b0, mode}, {31'b0, m_mode});
            chk("spr_rd", spr_rd, m_spr(spr_a));
        end
    end

    task automatic idle();
        commit = 0; ca = '0; eret = 0; spr_we = 0; spr_a = 0; spr_wd = 0;
        pc = 0; next_pc = 0; ea = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        idle(); commit = 1; spr_we = 1; spr_a = a; spr_wd = d;
        tick(); idle();
    endtask

    task automatic do_reset(input logic [NC-1:0] c);
        idle(); rst_n = 0; ca = c;
        tick(); rst_n = 1; idle();
    endtask

    initial begin
        idle();
        rst_n = 0; ca = '1;
        @(negedge clk);
        chk("rst_jisr_low", {31'b0, jisr}, 32'd0);
        chk("rst_redirect_low", {31'b0, redirect}, 32'd0);
        tick(); rst_n = 1; idle();
        chk("rst_sr", sr, 32'd0);
        chk("rst_mode", {31'b0, mode}, 32'd0);
        chk("rst_epc", epc, 32'd0);

        // Pending bits must be clear after reset even though ca was all ones.
        wr(3'd0, 32'hFFFF_FFFF);
        commit = 1;
        @(negedge clk);
        chk("rst_pend_clear", {31'b0, jisr}, 32'd0);
        tick(); idle();

        // Priority: lowest index wins, cause 3 is repeat type.
        commit = 1; ca = (23'd1 << 3) | (23'd1 << 9) | (23'd1 << 20);
        pc = 32'h1000; next_pc = 32'h1004; ea = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("prio_jisr", {31'b0, jisr}, 32'd1);
        chk("prio_il", {27'b0, il}, 32'd3);
        chk("prio_redirect_pc", redirect_pc, 32'h80);
        tick(); idle();
        chk("prio_epc", epc, 32'h1000);
        chk("prio_eca", eca, 32'h0010_0208);
        chk("prio_esr", esr, 32'hFFFF_FFFF);
        chk("prio_sr", sr, 32'd0);
        chk("prio_edata", edata, 32'hDEAD_BEEF);

        // Continue-type syscall from user mode.
        do_reset('0);
        wr(3'd0, 32'h1234);
        wr(3'd7, 32'd1);
        chk("cont_mode_user", {31'b0, mode}, 32'd1);
        commit = 1; ca = 23'd1 << 6; pc = 32'h100; next_pc = 32'h104;
        @(negedge clk);
        chk("cont_il", {27'b0, il}, 32'd6);
        tick(); idle();
        chk("cont_epc", epc, 32'h104);
        chk("cont_mode", {31'b0, mode}, 32'd0);
        chk("cont_esr", esr, 32'h1234);
        chk("cont_sr", sr, 32'd0);

        // Masked external cause stays pending until unmasked.
        do_reset('0);
        ca = 23'd1 << 9;
        tick(); idle();
        repeat (3) begin
            commit = 1;
            @(negedge clk);
            chk("masked_no_jisr", {31'b0, jisr}, 32'd0);
            tick();
        end
        idle();
        wr(3'd0, 32'h200);
        commit = 1; pc = 32'h2000; next_pc = 32'h2004;
        @(negedge clk);
        chk("sticky_jisr", {31'b0, jisr}, 32'd1);
        chk("sticky_il", {27'b0, il}, 32'd9);
        tick(); idle();
        chk("sticky_epc", epc, 32'h2004);
        chk("sticky_eca", eca, 32'h200);
        wr(3'd0, 32'h200);
        commit = 1;
        @(negedge clk);
        chk("sticky_pend_cleared", {31'b0, jisr}, 32'd0);
        tick(); idle();

        // ERET restores SR and mode saved by an earlier user-mode exception.
        do_reset('0);
        wr(3'd7, 32'd1);
        commit = 1; ca = 23'd1; pc = 32'h10; next_pc = 32'h14;
        tick(); idle();
        wr(3'd1, 32'h200);
        wr(3'd3, 32'h400);
        commit = 1; eret = 1;
        @(negedge clk);
        chk("eret_jisr", {31'b0, jisr}, 32'd0);
        chk("eret_redirect", {31'b0, redirect}, 32'd1);
        chk("eret_redirect_pc", redirect_pc, 32'h400);
        tick(); idle();
        chk("eret_sr", sr, 32'h200);
        chk("eret_mode", {31'b0, mode}, 32'd1);

        // Collision: exception beats ERET.
        commit = 1; eret = 1; ca = 23'd1 << 2; pc = 32'h3000; next_pc = 32'h3004;
        @(negedge clk);
        chk("coll_jisr", {31'b0, jisr}, 32'd1);
        chk("coll_redirect_pc", redirect_pc, SISR_T);
        tick(); idle();
        chk("coll_sr", sr, 32'd0);
        chk("coll_mode", {31'b0, mode}, 32'd0);
        chk("coll_epc", epc, 32'h3000);
        chk("coll_esr", esr, 32'h200);

        // User mode cannot write SPRs or ERET.
        wr(3'd7, 32'd1);
        wr(3'd0, 32'hFFFF);
        chk("user_wr_blocked", sr, 32'd0);
        commit = 1; eret = 1;
        tick(); idle();
        chk("user_eret_sr", sr, 32'd0);
        chk("user_eret_mode", {31'b0, mode}, 32'd1);

        // SPR write without commit is ignored; PTO/PTL readback.
        do_reset('0);
        spr_we = 1; spr_a = 3'd5; spr_wd = 32'h55;
        tick(); idle();
        chk("nocommit_pto", pto, 32'd0);
        wr(3'd5, 32'hA5A5_0000);
        wr(3'd6, 32'h1F);
        for (int a = 0; a < 8; a++) begin
            spr_a = 3'(a);
            tick();
        end
        spr_a = 3'd5;
        @(negedge clk);
        chk("rd_pto", spr_rd, 32'hA5A5_0000);
        tick(); idle();

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
